// File: rtl/hazard_sequencer_pkg.sv
// Shared opcode constants and sequencer state encodings for the 5-stage datapath.
// The decoder and immediate generator match on these same 12-bit codes.
package hazard_sequencer_pkg;

    localparam int OPCODE_W = 12;
    localparam int REG_W    = 5;

    // Upper 6 bits: major opcode; lower 6 bits: funct field for R-format.
    localparam logic [OPCODE_W-1:0] OP_ADD  = 12'h020;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 12'h022;
    localparam logic [OPCODE_W-1:0] OP_AND  = 12'h024;
    localparam logic [OPCODE_W-1:0] OP_OR   = 12'h025;
    localparam logic [OPCODE_W-1:0] OP_XOR  = 12'h026;
    localparam logic [OPCODE_W-1:0] OP_NOR  = 12'h027;
    localparam logic [OPCODE_W-1:0] OP_SLT  = 12'h02A;
    localparam logic [OPCODE_W-1:0] OP_SLL  = 12'h000;
    localparam logic [OPCODE_W-1:0] OP_SRL  = 12'h002;
    localparam logic [OPCODE_W-1:0] OP_ANDI = 12'h300;
    localparam logic [OPCODE_W-1:0] OP_ORI  = 12'h340;
    localparam logic [OPCODE_W-1:0] OP_XORI = 12'h380;
    localparam logic [OPCODE_W-1:0] OP_ADDI = 12'h200;
    localparam logic [OPCODE_W-1:0] OP_SLTI = 12'h280;
    localparam logic [OPCODE_W-1:0] OP_LW   = 12'h8C0;
    localparam logic [OPCODE_W-1:0] OP_SW   = 12'hAC0;
    localparam logic [OPCODE_W-1:0] OP_BEQ  = 12'h100;
    localparam logic [OPCODE_W-1:0] OP_BNE  = 12'h140;
    localparam logic [OPCODE_W-1:0] OP_J    = 12'h080;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_FLUSH      = 2'd2,
        ST_MEM_WAIT   = 2'd3
    } state_e;

endpackage

// File: rtl/hazard_sequencer_src_use_decode.sv
// Combinational opcode -> source-register usage decode; shared with the forwarding unit.
module src_use_decode
    import hazard_sequencer_pkg::*;
#(
    parameter int OPC_W = OPCODE_W
) (
    input  logic [OPC_W-1:0] opcode_i,
    output logic             rs_used_o,
    output logic             rt_used_o
);

    // Classify the ID opcode by which register fields it actually reads.
    always_comb begin
        rs_used_o = 1'b0;
        rt_used_o = 1'b0;
        case (opcode_i)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT: begin
                rs_used_o = 1'b1;
                rt_used_o = 1'b1;
            end
            OP_SLL, OP_SRL: begin
                rs_used_o = 1'b0;
                rt_used_o = 1'b1;
            end
            OP_SW, OP_BEQ, OP_BNE: begin
                rs_used_o = 1'b1;
                rt_used_o = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_XORI, OP_ADDI, OP_SLTI, OP_LW: begin
                rs_used_o = 1'b1;
                rt_used_o = 1'b0;
            end
            OP_J: begin
                rs_used_o = 1'b0;
                rt_used_o = 1'b0;
            end
            default: begin
                rs_used_o = 1'b0;
                rt_used_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline control sequencer: load-use stalls, taken-branch flushes and data-memory freezes,
// plus a saturating stall-cycle counter.
module hazard_sequencer
    import hazard_sequencer_pkg::*;
#(
    parameter int OPC_W          = OPCODE_W,
    parameter int REG_AW         = REG_W,
    parameter int BRANCH_PENALTY = 1,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OPC_W-1:0]  id_opcode,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_branch_taken,
    input  logic              dmem_busy,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_write,
    output logic              idex_bubble,
    output logic              exmem_write,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [2:0] FLUSH_RELOAD = 3'(BRANCH_PENALTY - 1);

    state_e            state_q, state_d;
    state_e            saved_q, saved_d;
    state_e            eff_state_s;
    logic [2:0]        flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0]  stall_count_q;
    logic              rs_used_s, rt_used_s;
    logic              hit_s;
    logic              stall_cycle_s;

    src_use_decode #(.OPC_W(OPC_W)) u_src_use_decode (
        .opcode_i  (id_opcode),
        .rs_used_o (rs_used_s),
        .rt_used_o (rt_used_s)
    );

    assign hit_s = ex_memread && (ex_rd != {REG_AW{1'b0}}) &&
                   ((rs_used_s && (ex_rd == id_rs)) || (rt_used_s && (ex_rd == id_rt)));

    // Next state and pipeline controls; a freeze resumes from the saved state.
    always_comb begin
        state_d     = state_q;
        saved_d     = saved_q;
        flush_cnt_d = flush_cnt_q;
        eff_state_s = (state_q == ST_MEM_WAIT) ? saved_q : state_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_write  = 1'b1;
        idex_bubble = 1'b0;
        exmem_write = 1'b1;
        if (!rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_write  = 1'b0;
            idex_bubble = 1'b1;
            exmem_write = 1'b0;
        end else if (dmem_busy) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            saved_d     = eff_state_s;
            state_d     = ST_MEM_WAIT;
        end else if (ex_branch_taken) begin
            // A branch overrides any load-use hit: the ID instruction is wrong-path.
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            if (BRANCH_PENALTY > 1) begin
                flush_cnt_d = FLUSH_RELOAD;
                state_d     = ST_FLUSH;
            end else begin
                flush_cnt_d = 3'd0;
                state_d     = ST_RUN;
            end
        end else begin
            case (eff_state_s)
                ST_FLUSH: begin
                    ifid_flush  = 1'b1;
                    flush_cnt_d = (flush_cnt_q != 3'd0) ? (flush_cnt_q - 3'd1) : 3'd0;
                    state_d     = (flush_cnt_q <= 3'd1) ? ST_RUN : ST_FLUSH;
                end
                ST_LOAD_STALL: begin
                    // EX now holds the bubble, so the same load cannot stall ID again.
                    state_d = ST_RUN;
                end
                default: begin
                    if (hit_s) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                        state_d     = ST_LOAD_STALL;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            endcase
        end
    end

    assign stall_cycle_s = !pc_write || ifid_flush;

    // State, saved-state and flush-counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            saved_q     <= ST_RUN;
            flush_cnt_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            saved_q     <= saved_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Saturating count of cycles that stall or flush the front end.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count_q <= {CNT_W{1'b0}};
        end else if (stall_cycle_s && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_q <= stall_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_count_q <= stall_count_q;
        end
    end

    assign stall_count = stall_count_q;

endmodule
